softmax_frame_ctl: RTL and testbench

Sequencer between the 16-bit TX FIFO, the softmax engine and the UART controller's packet interface. Pulls one frame of FRAME_LEN words from the FIFO, streams them into the engine, and starts it. Latches the 128-bit result and holds it valid until the UART reports transmission complete. Provides a frame counter, a busy flag and a sticky engine-timeout error for the SPI status register.

---
 rtl/softmax_frame_ctl.sv | 146 ++++++++++++++
 tb/tb_softmax_frame_ctl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_frame_ctl.sv
// Frame sequencer: pulls FRAME_LEN words from the TX FIFO into the softmax engine,
// then holds the engine result for the UART until it reports the packet sent.
module softmax_frame_ctl #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int PKT_WIDTH  = 128,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  err_clr,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] eng_data,
    output logic                  eng_data_vld,
    output logic                  eng_start,
    input  logic                  eng_done,
    input  logic [PKT_WIDTH-1:0]  eng_result,
    output logic [PKT_WIDTH-1:0]  pkt_data,
    output logic                  pkt_valid,
    input  logic                  pkt_done,
    output logic [15:0]           frame_cnt,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int RC_W = $clog2(FRAME_LEN + 1);
    localparam int TC_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        START,
        COMPUTE,
        SEND
    } state_t;

    state_t                 state_q;
    logic [RC_W-1:0]        rd_cnt_q;
    logic [RC_W-1:0]        rd_cnt_d;
    logic [TC_W-1:0]        tmo_cnt_q;
    logic [TC_W-1:0]        tmo_cnt_d;
    logic [15:0]            frame_cnt_q;
    logic [15:0]            frame_cnt_d;
    logic                   eng_data_vld_q;
    logic                   eng_start_q;
    logic [PKT_WIDTH-1:0]   pkt_data_q;
    logic                   pkt_valid_q;
    logic                   busy_q;
    logic                   timeout_err_q;

    always_comb begin
        rd_cnt_d    = rd_cnt_q + 1'b1;
        tmo_cnt_d   = tmo_cnt_q + 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Read strobe is combinational so a word can be popped every cycle.
    assign fifo_rd_en = (state_q == FETCH) && !fifo_empty && (rd_cnt_q < RC_W'(FRAME_LEN));

    // FIFO data lags its strobe by one cycle, which is exactly when eng_data_vld is high.
    assign eng_data     = eng_data_vld_q ? fifo_rd_data : '0;
    assign eng_data_vld = eng_data_vld_q;
    assign eng_start    = eng_start_q;
    assign pkt_data     = pkt_data_q;
    assign pkt_valid    = pkt_valid_q;
    assign frame_cnt    = frame_cnt_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_cnt_q       <= '0;
            tmo_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            eng_data_vld_q <= 1'b0;
            eng_start_q    <= 1'b0;
            pkt_data_q     <= '0;
            pkt_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            eng_data_vld_q <= fifo_rd_en;
            eng_start_q    <= 1'b0;
            // A timeout set later in this block overrides a simultaneous clear.
            if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q  <= FETCH;
                        busy_q   <= 1'b1;
                        rd_cnt_q <= '0;
                    end
                end
                FETCH: begin
                    if (fifo_rd_en) begin
                        rd_cnt_q <= rd_cnt_d;
                        if (rd_cnt_q == RC_W'(FRAME_LEN - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state_q     <= START;
                    eng_start_q <= 1'b1;
                end
                START: begin
                    state_q   <= COMPUTE;
                    tmo_cnt_q <= '0;
                end
                COMPUTE: begin
                    if (eng_done) begin
                        pkt_data_q  <= eng_result;
                        pkt_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end else if (tmo_cnt_q == TC_W'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                SEND: begin
                    if (pkt_done) begin
                        frame_cnt_q <= frame_cnt_d;
                        pkt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_frame_ctl.sv
// Directed bench for softmax_frame_ctl: cycle table for the first frame, then
// hand-written sequences for FIFO stalls, timeout, reset, counter wrap and enable drop.
module tb_softmax_frame_ctl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         err_clr;
    logic         fifo_empty;
    logic [15:0]  fifo_rd_data;
    logic         fifo_rd_en;
    logic [15:0]  eng_data;
    logic         eng_data_vld;
    logic         eng_start;
    logic         eng_done;
    logic [127:0] eng_result;
    logic [127:0] pkt_data;
    logic         pkt_valid;
    logic         pkt_done;
    logic [15:0]  frame_cnt;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    softmax_frame_ctl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .err_clr      (err_clr),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .eng_data     (eng_data),
        .eng_data_vld (eng_data_vld),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_result   (eng_result),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_done     (pkt_done),
        .frame_cnt    (frame_cnt),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Behavioural FIFO: bench pushes, DUT strobe pops with one-cycle read latency.
    logic [15:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    initial fifo_rd_data = '0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] got [0:31];

    typedef struct {
        logic        rd_en;
        logic        vld;
        logic [15:0] data;
        logic        start;
    } vec_t;
    vec_t tbl [0:10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_frame(input int hold);
        enable = 1'b1;
        repeat (hold) @(negedge clk);
        enable = 1'b0;
    endtask

    // Returns at the negedge inside the eng_start cycle.
    task automatic run_to_start(input int budget, output int nw, output bit seen);
        nw   = 0;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (eng_data_vld && nw < 32) begin
                got[nw] = eng_data;
                nw++;
            end
            if (eng_start) seen = 1'b1;
        end
    endtask

    task automatic finish_frame(input logic [127:0] res);
        @(negedge clk);
        eng_done   = 1'b1;
        eng_result = res;
        @(negedge clk);
        eng_done = 1'b0;
        chk("fin_pkt_valid", pkt_valid, 1);
        chk("fin_pkt_data", pkt_data, res);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("fin_busy", busy, 0);
        $display("frame sent: result %h frame_cnt %0d", res, frame_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  nw;
        bit  seen;
        int  cnt;
        bit  bad;
        logic [127:0] res1;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0001, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h0002, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h0003, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'h0004, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h0005, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0006, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'h0007, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'h0008, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0};

        rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0;
        eng_done = 1'b0; eng_result = '0; pkt_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_eng_vld", eng_data_vld, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // Frame 1: cycle-exact load sequence from a full FIFO.
        for (int i = 1; i <= 8; i++) push(16'(i));
        @(negedge clk);
        chk("idle_no_read", fifo_rd_en, 0);
        enable = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            enable = 1'b0;
            chk($sformatf("t1_rd_en[%0d]", k), fifo_rd_en, tbl[k].rd_en);
            chk($sformatf("t1_vld[%0d]", k), eng_data_vld, tbl[k].vld);
            chk($sformatf("t1_data[%0d]", k), eng_data, tbl[k].data);
            chk($sformatf("t1_start[%0d]", k), eng_start, tbl[k].start);
        end
        chk("t1_busy_compute", busy, 1);
        repeat (4) @(negedge clk);
        res1 = 128'hDEAD0000_11112222_33334444_5555BEEF;
        eng_done = 1'b1; eng_result = res1;
        @(negedge clk);
        eng_done = 1'b0; eng_result = 128'h0123;
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i == 10) eng_done = 1'b1;
            if (i == 11) eng_done = 1'b0;
            if (!pkt_valid || pkt_data !== res1 || !busy) bad = 1'b1;
            @(negedge clk);
        end
        chk("t1_pkt_held", bad, 0);
        chk("t1_frame_cnt_pre", frame_cnt, 0);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("t1_pkt_valid_drop", pkt_valid, 0);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_busy_drop", busy, 0);
        $display("frame sent: result %h frame_cnt %0d", res1, frame_cnt);

        // Frame 2: FIFO runs dry after 3 words, refilled 20 cycles later.
        push(16'h0011); push(16'h0012); push(16'h0013);
        start_frame(1);
        nw = 0; seen = 1'b0; cnt = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (i == 22) for (int j = 4; j <= 8; j++) push(16'(16'h0010 + j));
            if (i >= 4 && i < 22 && (fifo_rd_en || eng_data_vld || eng_start)) cnt++;
            if (eng_data_vld && nw < 32) begin
                got[nw] = eng_data;
                nw++;
            end
            if (eng_start) seen = 1'b1;
        end
        chk("t2_start_seen", seen, 1);
        chk("t2_words", nw, 8);
        for (int j = 0; j < 8; j++) chk($sformatf("t2_word[%0d]", j), got[j], 16'(16'h0011 + j));
        chk("t2_gap_activity", cnt, 0);
        chk("t2_no_timeout", timeout_err, 0);
        finish_frame(128'h2222);
        chk("t2_frame_cnt", frame_cnt, 2);

        // Frame 3: engine never answers; err_clr on the expiry cycle loses to the set.
        for (int j = 0; j < 8; j++) push(16'(16'h0021 + j));
        start_frame(1);
        run_to_start(40, nw, seen);
        chk("t3_start_seen", seen, 1);
        repeat (1023) @(negedge clk);
        chk("t3_err_early", timeout_err, 0);
        chk("t3_busy_early", busy, 1);
        @(negedge clk);
        chk("t3_err_expiry_cycle", timeout_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_err_set", timeout_err, 1);
        chk("t3_busy_idle", busy, 0);
        chk("t3_no_pkt", pkt_valid, 0);
        chk("t3_frame_cnt", frame_cnt, 2);
        @(negedge clk);
        chk("t3_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_err_cleared", timeout_err, 0);
        $display("frame timed out: frame_cnt %0d", frame_cnt);

        // Frame 4: eng_done on the expiry cycle wins.
        for (int j = 0; j < 8; j++) push(16'(16'h0031 + j));
        start_frame(1);
        run_to_start(40, nw, seen);
        chk("t4_start_seen", seen, 1);
        repeat (1024) @(negedge clk);
        eng_done = 1'b1; eng_result = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
        @(negedge clk);
        eng_done = 1'b0;
        chk("t4_pkt_valid", pkt_valid, 1);
        chk("t4_no_err", timeout_err, 0);
        chk("t4_pkt_data", pkt_data, 128'h4444_0000_0000_0000_0000_0000_0000_0004);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("t4_frame_cnt", frame_cnt, 3);
        $display("frame sent: late done, frame_cnt %0d", frame_cnt);

        // Frame 5: reset during COMPUTE.
        for (int j = 0; j < 8; j++) push(16'(16'h0051 + j));
        start_frame(1);
        run_to_start(40, nw, seen);
        chk("t5_start_seen", seen, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_frame_cnt", frame_cnt, 0);
        chk("t5_rst_pkt_valid", pkt_valid, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        eng_done = 1'b1; eng_result = 128'h5555;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        chk("t5_done_ignored", pkt_valid, 0);
        chk("t5_still_idle", busy, 0);
        chk("t5_pkt_data_zero", pkt_data, 0);
        $display("reset during compute: frame_cnt %0d", frame_cnt);

        // Frame 6: frame counter wraps from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        for (int j = 0; j < 8; j++) push(16'(16'h0061 + j));
        start_frame(1);
        run_to_start(40, nw, seen);
        chk("t6_start_seen", seen, 1);
        finish_frame(128'h6666);
        chk("t6_frame_cnt_wrap", frame_cnt, 0);

        // Frame 7: enable dropped mid-FETCH with 16 words queued.
        for (int j = 0; j < 16; j++) push(16'(16'h0041 + j));
        start_frame(3);
        run_to_start(40, nw, seen);
        chk("t7_start_seen", seen, 1);
        finish_frame(128'h7777);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
        end
        chk("t7_no_more_reads", cnt, 0);
        chk("t7_fifo_left", wr_ptr - rd_ptr, 8);
        chk("t7_frame_cnt", frame_cnt, 1);
        chk("t7_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
